collision_responder: RTL and testbench



---
 rtl/collision_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_collision_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_responder.sv
// ----------------------------------------------------------------------------
// collision_responder
//
// Consumer side of the collision interface driven by the game controller.
// Collision events qualified by SingleHitPulse are latched during a frame and
// acted on once, on the startOfFrame cycle. The game-state FSM
// (IDLE / PLAY / HIT / OVER) keeps lives and score and produces the
// visibility, respawn and ghost-reset controls. All outputs are registered,
// so every effect appears one clock after the cycle that caused it.
//
// Optional feature (define to enable):
//   COLLISION_RESPONDER_BONUS_LIFE_EN - one extra life, once per game, when
//   the score first reaches BONUS_SCORE.
//
// Ports:
//   clk                in   system clock
//   resetN             in   asynchronous, active-low reset
//   startOfFrame       in   one-cycle pulse per frame
//   SingleHitPulse     in   qualifier; collision levels latch only while high
//   hit_player         in   smiley vs hazard/border collision (level)
//   hit_pickup         in   smiley vs pickup collision (level)
//   hit_ghost          in   ghost vs hazard/border collision (level)
//   start_btn          in   one-cycle start request
//   lives              out  remaining lives (3 bits)
//   score              out  current score (SCORE_W bits, saturating)
//   playing            out  high in PLAY and HIT
//   game_over          out  high in OVER
//   player_visible     out  smiley draw enable
//   respawn_pulse      out  one cycle: return smiley to spawn
//   ghost_reset_pulse  out  one cycle: reverse/reset ghost
// ----------------------------------------------------------------------------
module collision_responder #(
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned MAX_LIVES     = 7,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 4,
    parameter int unsigned SCORE_W       = 16,
    parameter int unsigned PICKUP_POINTS = 10,
    parameter int unsigned BONUS_SCORE   = 500
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               SingleHitPulse,
    input  logic               hit_player,
    input  logic               hit_pickup,
    input  logic               hit_ghost,
    input  logic               start_btn,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               playing,
    output logic               game_over,
    output logic               player_visible,
    output logic               respawn_pulse,
    output logic               ghost_reset_pulse
);

    localparam int unsigned CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HIT,
        OVER
    } state_t;

    state_t             state_q;
    logic               lat_player_q;
    logic               lat_pickup_q;
    logic               lat_ghost_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               playing_q;
    logic               game_over_q;
    logic               visible_q;
    logic               respawn_q;
    logic               ghost_rst_q;

    // Qualified collision inputs for this cycle
    logic q_player;
    logic q_pickup;
    logic q_ghost;

    // Frame-processing results, only consumed on startOfFrame in PLAY/HIT
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] score_proc;
    logic               hit_dec;
    logic               bonus_now;
    logic [3:0]         lives_calc;
    logic [2:0]         lives_proc;
    logic               cnt_last;
    logic               blink_edge;

    assign q_player = SingleHitPulse & hit_player;
    assign q_pickup = SingleHitPulse & hit_pickup;
    assign q_ghost  = SingleHitPulse & hit_ghost;

`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
    localparam logic [SCORE_W:0] BONUS_TH = (SCORE_W+1)'(BONUS_SCORE);

    logic bonus_done_q;

    assign bonus_now = lat_pickup_q && !bonus_done_q
                       && ({1'b0, score_q} < BONUS_TH)
                       && ({1'b0, score_inc} >= BONUS_TH);
`else
    logic unused_bonus_score;

    assign unused_bonus_score = ^BONUS_SCORE;
    assign bonus_now          = 1'b0;
`endif

    always_comb begin
        score_sum  = {1'b0, score_q} + (SCORE_W+1)'(PICKUP_POINTS);
        score_inc  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        score_proc = lat_pickup_q ? score_inc : score_q;

        // A hit only costs a life in PLAY and never drives lives below zero
        hit_dec    = (state_q == PLAY) && lat_player_q && (lives_q != '0);

        // Bonus and hit in the same frame cancel out to a net change of zero
        lives_calc = {1'b0, lives_q} + {3'b000, bonus_now} - {3'b000, hit_dec};
        lives_proc = (lives_calc > 4'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives_calc[2:0];

        cnt_last   = (cnt_q == CNT_W'(INVULN_FRAMES - 1));
        blink_edge = ((32'(cnt_q) % BLINK_FRAMES) == (BLINK_FRAMES - 1));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            lat_player_q <= 1'b0;
            lat_pickup_q <= 1'b0;
            lat_ghost_q  <= 1'b0;
            cnt_q        <= '0;
            lives_q      <= '0;
            score_q      <= '0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            visible_q    <= 1'b1;
            respawn_q    <= 1'b0;
            ghost_rst_q  <= 1'b0;
`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
            bonus_done_q <= 1'b0;
`endif
        end else begin
            respawn_q   <= 1'b0;
            ghost_rst_q <= 1'b0;

            // On startOfFrame the latches are reloaded rather than cleared so
            // an event coinciding with the frame boundary lands in the next frame.
            if (startOfFrame) begin
                lat_player_q <= q_player;
                lat_pickup_q <= q_pickup;
                lat_ghost_q  <= q_ghost;
            end else begin
                lat_player_q <= lat_player_q | q_player;
                lat_pickup_q <= lat_pickup_q | q_pickup;
                lat_ghost_q  <= lat_ghost_q  | q_ghost;
            end

            case (state_q)
                // Outside a game nothing is scored, so stale events are dropped
                // and a new game always starts from clean latches.
                IDLE, OVER: begin
                    lat_player_q <= 1'b0;
                    lat_pickup_q <= 1'b0;
                    lat_ghost_q  <= 1'b0;
                    if (start_btn) begin
                        state_q     <= PLAY;
                        lives_q     <= 3'(INIT_LIVES);
                        score_q     <= '0;
                        visible_q   <= 1'b1;
                        playing_q   <= 1'b1;
                        game_over_q <= 1'b0;
                        cnt_q       <= '0;
`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
                        bonus_done_q <= 1'b0;
`endif
                    end
                end

                PLAY: begin
                    if (startOfFrame) begin
                        score_q     <= score_proc;
                        lives_q     <= lives_proc;
                        ghost_rst_q <= lat_ghost_q;
`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
                        if (bonus_now) bonus_done_q <= 1'b1;
`endif
                        if (hit_dec) begin
                            respawn_q <= 1'b1;
                            visible_q <= 1'b0;
                            if (lives_proc == '0) begin
                                state_q     <= OVER;
                                playing_q   <= 1'b0;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= HIT;
                                cnt_q   <= '0;
                            end
                        end
                    end
                end

                HIT: begin
                    if (startOfFrame) begin
                        score_q     <= score_proc;
                        lives_q     <= lives_proc;
                        ghost_rst_q <= lat_ghost_q;
`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
                        if (bonus_now) bonus_done_q <= 1'b1;
`endif
                        // The counter value before this frame's increment
                        // decides both the blink and the exit from HIT.
                        if (cnt_last) begin
                            state_q   <= PLAY;
                            visible_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (blink_edge) visible_q <= ~visible_q;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign lives             = lives_q;
    assign score             = score_q;
    assign playing           = playing_q;
    assign game_over         = game_over_q;
    assign player_visible    = visible_q;
    assign respawn_pulse     = respawn_q;
    assign ghost_reset_pulse = ghost_rst_q;

endmodule

// File: tb/tb_collision_responder.sv
// ----------------------------------------------------------------------------
// tb_collision_responder
//
// Directed bench for collision_responder with default parameters. The driver
// pushes the hand-computed expected outputs for every startOfFrame/start_btn
// cycle into a queue; the monitor pops and compares on the falling edge after
// each such cycle, and checks that the pulse outputs are low on every other
// cycle.
// ----------------------------------------------------------------------------
module tb_collision_responder;

    localparam int SCORE_W = 16;
    localparam int SAT     = (1 << SCORE_W) - 1;
`ifdef COLLISION_RESPONDER_BONUS_LIFE_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               SingleHitPulse;
    logic               hit_player;
    logic               hit_pickup;
    logic               hit_ghost;
    logic               start_btn;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic               playing;
    logic               game_over;
    logic               player_visible;
    logic               respawn_pulse;
    logic               ghost_reset_pulse;

    collision_responder dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .SingleHitPulse    (SingleHitPulse),
        .hit_player        (hit_player),
        .hit_pickup        (hit_pickup),
        .hit_ghost         (hit_ghost),
        .start_btn         (start_btn),
        .lives             (lives),
        .score             (score),
        .playing           (playing),
        .game_over         (game_over),
        .player_visible    (player_visible),
        .respawn_pulse     (respawn_pulse),
        .ghost_reset_pulse (ghost_reset_pulse)
    );

    typedef struct {
        string name;
        int    lives;
        int    score;
        bit    playing;
        bit    over;
        bit    vis;
        bit    resp;
        bit    ghost;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    bit   ev_q     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------ monitor
    always @(posedge clk) ev_q <= startOfFrame | start_btn;

    always @(negedge clk) begin
        if (ev_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: DUT processed an event with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (int'(lives) != e.lives || int'(score) != e.score ||
                    playing !== e.playing || game_over !== e.over ||
                    player_visible !== e.vis || respawn_pulse !== e.resp ||
                    ghost_reset_pulse !== e.ghost) begin
                    failures++;
                    $display("FAIL %s: got lives=%0d score=%0d playing=%b game_over=%b visible=%b respawn=%b ghost=%b; expected lives=%0d score=%0d playing=%b game_over=%b visible=%b respawn=%b ghost=%b",
                             e.name, lives, score, playing, game_over, player_visible,
                             respawn_pulse, ghost_reset_pulse, e.lives, e.score,
                             e.playing, e.over, e.vis, e.resp, e.ghost);
                end
            end
        end else begin
            checks++;
            if (respawn_pulse !== 1'b0 || ghost_reset_pulse !== 1'b0) begin
                failures++;
                $display("FAIL pulse_width @%0t: respawn=%b ghost=%b, expected both 0",
                         $time, respawn_pulse, ghost_reset_pulse);
            end
        end
    end

    // ------------------------------------------------------------------ driver
    task automatic cyc(input bit sof, input bit shp, input bit hp, input bit hk,
                       input bit hg, input bit sb);
        startOfFrame   = sof;
        SingleHitPulse = shp;
        hit_player     = hp;
        hit_pickup     = hk;
        hit_ghost      = hg;
        start_btn      = sb;
        @(posedge clk);
        #1;
        startOfFrame   = 1'b0;
        SingleHitPulse = 1'b0;
        hit_player     = 1'b0;
        hit_pickup     = 1'b0;
        hit_ghost      = 1'b0;
        start_btn      = 1'b0;
    endtask

    task automatic expect_out(input string n, input int l, input int s, input bit p,
                              input bit o, input bit v, input bit r, input bit g);
        exp_t t;
        t.name    = n;
        t.lives   = l;
        t.score   = s;
        t.playing = p;
        t.over    = o;
        t.vis     = v;
        t.resp    = r;
        t.ghost   = g;
        exp_q.push_back(t);
    endtask

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", n, got, want);
        end
    endtask

    task automatic check_reset_state(input string n);
        chk({n, "_lives"},   int'(lives), 0);
        chk({n, "_score"},   int'(score), 0);
        chk({n, "_playing"}, int'(playing), 0);
        chk({n, "_over"},    int'(game_over), 0);
        chk({n, "_visible"}, int'(player_visible), 1);
        chk({n, "_respawn"}, int'(respawn_pulse), 0);
        chk({n, "_ghost"},   int'(ghost_reset_pulse), 0);
    endtask

    // Invulnerability window: visibility starts low and toggles after counter
    // values 3, 7, 11, ...; the 60th frame returns to PLAY with visible high.
    task automatic run_hit(input int l, input int s, input bit inject);
        bit v;
        for (int c = 0; c < 60; c++) begin
            if (inject && c == 5) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            v = (c == 59) ? 1'b1 : bit'(((c + 1) / 4) % 2);
            expect_out($sformatf("hit_frame%0d", c), l, s, 1'b1, 1'b0, v, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int s;
        int l;
        resetN         = 1'b1;
        startOfFrame   = 1'b0;
        SingleHitPulse = 1'b0;
        hit_player     = 1'b0;
        hit_pickup     = 1'b0;
        hit_ghost      = 1'b0;
        start_btn      = 1'b0;
        #2 resetN = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        resetN = 1'b1;

        // IDLE ignores frames and collisions
        expect_out("idle_frame", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        expect_out("start", 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Two pickups inside one frame count once
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("double_pickup", 3, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        expect_out("start_ignored_in_play", 3, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Ghost event on the frame cycle carries into the next frame
        expect_out("ghost_on_sof_now", 3, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("ghost_on_sof_next", 3, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Player hit together with a pickup
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("hit1", 2, 20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_hit(2, 20, 1'b1);
        expect_out("play_after_hit", 2, 20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("hit2", 1, 20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_hit(1, 20, 1'b0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("hit3_over", 0, 20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("over_frozen", 0, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        expect_out("restart", 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of HIT
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("hit_before_reset", 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("hit_frame0_pre_reset", 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 resetN = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        expect_out("idle_after_reset", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lives 2, then pickups through the bonus threshold and into saturation
        expect_out("start3", 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("hit_g3", 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_hit(2, 0, 1'b0);
        for (int n = 1; n <= 6555; n++) begin
            s = (10 * n > SAT) ? SAT : 10 * n;
            l = (BONUS_EN && 10 * n >= 500) ? 3 : 2;
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_out($sformatf("pickup_chain%0d", n), l, s, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
